// File: rtl/svf_window_ctrl.sv
// Measurement-window controller for the SVF accumulator: sequences warm-up and
// measurement windows via spu_clear_o and buffers per-window totals in a FWFT FIFO.
//
// state   | meaning
// IDLE    | no run; spu held clear
// WARMUP  | spu held clear for max(warmup_len,1) cycles
// MEASURE | spu accumulates for window_len cycles
// CAPTURE | push spu total + window index; spu cleared for one cycle
module svf_window_ctrl #(
  parameter int SVF_W      = 20,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] warmup_len_i,
  input  logic [CNT_W-1:0] window_len_i,
  input  logic [7:0]       num_windows_i,
  input  logic [SVF_W-1:0] spu_total_svf_i,
  output logic             spu_clear_o,
  output logic             sample_valid_o,
  output logic [SVF_W-1:0] sample_data_o,
  output logic [7:0]       sample_idx_o,
  input  logic             sample_ready_i,
  output logic             busy_o,
  output logic             overflow_o,
  output logic [7:0]       dropped_cnt_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WARMUP, MEASURE, CAPTURE} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] window_len_q;
  logic [7:0]       num_windows_q;
  logic [7:0]       idx_q;
  logic             start_ok;
  logic             cnt_tc;
  logic             last_window;
  logic             push;

  assign start_ok    = (state == IDLE) && start_i && !stop_i;
  assign cnt_tc      = (cnt == CNT_W'(1));
  assign last_window = (num_windows_q != 8'd0) && (idx_q == num_windows_q - 8'd1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_ok) next_state = WARMUP;
      WARMUP:  if (stop_i) next_state = IDLE;
               else if (cnt_tc) next_state = MEASURE;
      MEASURE: if (stop_i) next_state = IDLE;
               else if (cnt_tc) next_state = CAPTURE;
      CAPTURE: if (stop_i || last_window) next_state = IDLE;
               else next_state = MEASURE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state != IDLE);
    push   = (state == CAPTURE);
  end

  // Clear is registered from next_state so spu sees it aligned with the state it describes.
  always_ff @(posedge clk) begin
    if (reset) spu_clear_o <= 1'b1;
    else       spu_clear_o <= (next_state != MEASURE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= '0;
      window_len_q  <= CNT_W'(1);
      num_windows_q <= 8'd0;
      idx_q         <= 8'd0;
    end else if (start_ok) begin
      cnt           <= (warmup_len_i == '0) ? CNT_W'(1) : warmup_len_i;
      window_len_q  <= (window_len_i == '0) ? CNT_W'(1) : window_len_i;
      num_windows_q <= num_windows_i;
      idx_q         <= 8'd0;
    end else begin
      case (state)
        WARMUP:  cnt <= cnt_tc ? window_len_q : cnt - CNT_W'(1);
        MEASURE: cnt <= cnt - CNT_W'(1);
        CAPTURE: begin
          cnt   <= window_len_q;
          idx_q <= idx_q + 8'd1;
        end
        default: cnt <= cnt;
      endcase
    end
  end

  logic [SVF_W+7:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             pop, full, accept, drop;

  assign pop    = (count != '0) && sample_ready_i;
  assign full   = (count == DEPTH_C);
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= {idx_q, spu_total_svf_i};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign sample_valid_o = (count != '0);
  assign sample_data_o  = mem[rd_ptr][SVF_W-1:0];
  assign sample_idx_o   = mem[rd_ptr][SVF_W+7:SVF_W];

  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      overflow_o    <= 1'b0;
      dropped_cnt_o <= 8'd0;
    end else if (drop) begin
      overflow_o <= 1'b1;
      if (dropped_cnt_o != 8'hFF) dropped_cnt_o <= dropped_cnt_o + 8'd1;
    end
  end

endmodule

// File: tb/tb_svf_window_ctrl.sv
// Randomized scoreboard bench for svf_window_ctrl: expected phase per cycle is
// derived arithmetically from the run start time and config; samples go to a model FIFO.
module tb_svf_window_ctrl;
  localparam int SVF_W = 20;
  localparam int CNT_W = 16;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start_i = 1'b0;
  logic             stop_i = 1'b0;
  logic [CNT_W-1:0] warmup_len_i = '0;
  logic [CNT_W-1:0] window_len_i = '0;
  logic [7:0]       num_windows_i = '0;
  logic [SVF_W-1:0] spu_total_svf_i = '0;
  logic             spu_clear_o;
  logic             sample_valid_o;
  logic [SVF_W-1:0] sample_data_o;
  logic [7:0]       sample_idx_o;
  logic             sample_ready_i = 1'b0;
  logic             busy_o;
  logic             overflow_o;
  logic [7:0]       dropped_cnt_o;

  svf_window_ctrl #(.SVF_W(SVF_W), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .stop_i(stop_i),
    .warmup_len_i(warmup_len_i), .window_len_i(window_len_i),
    .num_windows_i(num_windows_i), .spu_total_svf_i(spu_total_svf_i),
    .spu_clear_o(spu_clear_o), .sample_valid_o(sample_valid_o),
    .sample_data_o(sample_data_o), .sample_idx_o(sample_idx_o),
    .sample_ready_i(sample_ready_i), .busy_o(busy_o),
    .overflow_o(overflow_o), .dropped_cnt_o(dropped_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk); #1;
    spu_total_svf_i = SVF_W'($urandom);
  end

  typedef struct {logic [7:0] idx; logic [SVF_W-1:0] data;} smp_t;
  smp_t exp_q[$];

  int tests = 0;
  int fails = 0;
  bit m_active = 0;
  int t0 = 0, m_w = 1, m_l = 1, m_n = 0;
  bit m_ovf = 0;
  int m_drop = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // 0 idle, 1 warm-up, 2 measure, 3 capture; win = window number of that cycle
  task automatic phase(output int ph, output int win);
    int r, m;
    ph = 0; win = 0;
    if (m_active) begin
      r = cyc - t0;
      if (r >= 1 && r <= m_w) ph = 1;
      else if (r > m_w) begin
        m   = r - m_w - 1;
        win = m / (m_l + 1);
        ph  = (m % (m_l + 1) == m_l) ? 3 : 2;
      end
    end
  endtask

  // Monitor / scoreboard
  initial forever begin
    int ph, win;
    smp_t s;
    @(negedge clk);
    if (reset) begin
      m_active = 0; exp_q.delete(); m_ovf = 0; m_drop = 0;
    end else begin
      phase(ph, win);
      chk("busy", busy_o, ph != 0);
      chk("spu_clear", spu_clear_o, ph != 2);
      chk("valid", sample_valid_o, exp_q.size() != 0);
      chk("overflow", overflow_o, m_ovf);
      chk("dropped_cnt", dropped_cnt_o, m_drop);
      if (exp_q.size() != 0 && sample_valid_o) begin
        chk("sample_idx", sample_idx_o, exp_q[0].idx);
        chk("sample_data", sample_data_o, exp_q[0].data);
      end
      if (exp_q.size() != 0 && sample_ready_i) void'(exp_q.pop_front());
      if (ph == 0) begin
        if (start_i && !stop_i) begin
          m_active = 1; t0 = cyc;
          m_w = (warmup_len_i == 0) ? 1 : int'(warmup_len_i);
          m_l = (window_len_i == 0) ? 1 : int'(window_len_i);
          m_n = int'(num_windows_i);
          m_ovf = 0; m_drop = 0;
        end
      end else begin
        if (ph == 3) begin
          s.idx = 8'(win % 256); s.data = spu_total_svf_i;
          if (exp_q.size() < DEPTH) exp_q.push_back(s);
          else begin m_ovf = 1; if (m_drop < 255) m_drop++; end
          if (m_n != 0 && win == m_n - 1) m_active = 0;
        end
        if (stop_i) m_active = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_run(input int w, input int l, input int n);
    warmup_len_i = CNT_W'(w); window_len_i = CNT_W'(l); num_windows_i = 8'(n);
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
    warmup_len_i = CNT_W'($urandom); window_len_i = CNT_W'($urandom);
    num_windows_i = 8'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (!busy_o) return;
    end
    fails++; tests++;
    $display("FAIL wait_idle: busy_o still 1 after %0d cycles, expected 0", budget);
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_data", sample_data_o, 0);
    chk("reset_idx", sample_idx_o, 0);
    chk("reset_clear", spu_clear_o, 1);
    tick(1);

    sample_ready_i = 1'b1;
    start_run(3, 4, 2); wait_idle(100); tick(3);
    start_run(0, 0, 1); wait_idle(100); tick(3);

    sample_ready_i = 1'b0;
    start_run(5, 2, 0); tick(35);
    stop_i = 1'b1; tick(1); stop_i = 1'b0;
    sample_ready_i = 1'b1; tick(8);

    start_run(2, 4, 3); tick(8);
    stop_i = 1'b1; tick(1); stop_i = 1'b0;
    wait_idle(20); tick(6);

    sample_ready_i = 1'b0;
    start_run(1, 2, 0); tick(14);
    sample_ready_i = 1'b1; tick(12);
    for (int i = 0; i < 30; i++) begin sample_ready_i = 1'($urandom); tick(1); end
    stop_i = 1'b1; tick(1); stop_i = 1'b0;
    sample_ready_i = 1'b1; tick(6);

    start_run(1, 6, 1); tick(3);
    warmup_len_i = 16'd9; window_len_i = 16'd9; num_windows_i = 8'd9;
    start_i = 1'b1; tick(1); start_i = 1'b0;
    wait_idle(50); tick(4);

    start_i = 1'b1; stop_i = 1'b1; tick(1);
    start_i = 1'b0; stop_i = 1'b0; tick(3);

    for (int it = 0; it < 25; it++) begin
      int len;
      start_run($urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 4));
      len = $urandom_range(5, 45);
      for (int c = 0; c < len; c++) begin
        sample_ready_i = ($urandom_range(0, 3) != 0);
        start_i = ($urandom_range(0, 7) == 0);
        stop_i  = ($urandom_range(0, 29) == 0);
        tick(1);
      end
      start_i = 1'b0;
      stop_i = 1'b1; tick(1); stop_i = 1'b0;
      wait_idle(10);
      tick($urandom_range(0, 3));
    end

    sample_ready_i = 1'b0;
    start_run(2, 2, 0); tick(15);
    reset = 1'b1; tick(1); reset = 1'b0;
    tick(3);
    sample_ready_i = 1'b1;
    start_run(0, 1, 3); wait_idle(50); tick(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
